// File: rtl/s386_pattern_driver.sv
// s386_pattern_driver
// Stimulus and response end of the s386 controller self-test harness.
// A 7-bit LFSR feeds the netlist primary inputs and a 7-bit MISR compacts
// the netlist primary outputs. One start pulse runs a fixed number of
// patterns, then a short flush with zero inputs, then the driver parks in
// DONE with a pass flag.

module s386_pattern_driver #(
    parameter int unsigned NUM_PATTERNS = 256,    // 1..65535
    parameter logic [6:0]  LFSR_SEED    = 7'h01,  // 0 is replaced by 7'h01
    parameter logic [6:0]  MISR_SEED    = 7'h00,
    parameter int unsigned FLUSH_CYCLES = 2,      // 0..15
    parameter logic [6:0]  GOLDEN_SIG   = 7'h00
) (
    input  logic        CK,
    input  logic        RST,
    input  logic        start,
    output logic [6:0]  pi_out,
    input  logic [6:0]  dut_po,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [6:0]  signature,
    output logic [15:0] pattern_count
);

    // FSM encoding
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // An all-zero seed would lock the LFSR, so it is swapped for 7'h01.
    localparam logic [6:0]  SEED_EFF   = (LFSR_SEED == 7'h00) ? 7'h01 : LFSR_SEED;
    localparam logic [15:0] LAST_PAT   = 16'(NUM_PATTERNS - 1);
    localparam logic [3:0]  LAST_FLUSH = 4'(FLUSH_CYCLES - 1);
    localparam bit          HAS_FLUSH  = (FLUSH_CYCLES != 0);

    logic [1:0]  state_q, state_d;
    logic [6:0]  lfsr_q,  lfsr_d;    // next value to be presented on pi_out
    logic [6:0]  misr_q,  misr_d;
    logic [6:0]  pi_q,    pi_d;
    logic [15:0] cnt_q,   cnt_d;
    logic [3:0]  fcnt_q,  fcnt_d;
    logic        pass_q,  pass_d;

    logic [6:0]  misr_comp;          // MISR value after one compaction step
    logic        last_pat;
    logic        last_flush;

    // x^7 + x^6 + 1 Fibonacci step, shared by LFSR and MISR feedback
    function automatic logic [6:0] step7(input logic [6:0] x);
        return {x[5:0], x[6] ^ x[5]};
    endfunction

    // One compaction step; dut_po is the netlist response to the pi_out
    // currently being presented.
    always_comb begin
        misr_comp  = step7(misr_q) ^ dut_po;
        last_pat   = (cnt_q == LAST_PAT);
        last_flush = (fcnt_q == LAST_FLUSH);
    end

    // Next-state logic for the run sequencer and its datapath
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        misr_d  = misr_q;
        pi_d    = pi_q;
        cnt_d   = cnt_q;
        fcnt_d  = fcnt_q;
        pass_d  = pass_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // MISR and counters frozen; pi_out already 0 here.
                if (start) begin
                    state_d = S_RUN;
                    pi_d    = SEED_EFF;
                    lfsr_d  = step7(SEED_EFF);
                    misr_d  = MISR_SEED;
                    cnt_d   = 16'd0;
                    fcnt_d  = 4'd0;
                    pass_d  = 1'b0;
                end
            end

            S_RUN: begin
                misr_d = misr_comp;
                cnt_d  = cnt_q + 16'd1;
                lfsr_d = step7(lfsr_q);
                if (last_pat) begin
                    pi_d = 7'h00;
                    if (HAS_FLUSH) begin
                        state_d = S_FLUSH;
                        fcnt_d  = 4'd0;
                    end else begin
                        state_d = S_DONE;
                        pass_d  = (misr_comp == GOLDEN_SIG);
                    end
                end else begin
                    pi_d = lfsr_q;
                end
            end

            S_FLUSH: begin
                // Inputs held at zero while late responses drain into the MISR.
                misr_d = misr_comp;
                pi_d   = 7'h00;
                fcnt_d = fcnt_q + 4'd1;
                if (last_flush) begin
                    state_d = S_DONE;
                    pass_d  = (misr_comp == GOLDEN_SIG);
                end
            end

            default: begin
                state_d = S_IDLE;
                pi_d    = 7'h00;
            end
        endcase
    end

    // State registers; RST wins over every other input
    always_ff @(posedge CK) begin
        if (RST) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED_EFF;
            misr_q  <= MISR_SEED;
            pi_q    <= 7'h00;
            cnt_q   <= 16'd0;
            fcnt_q  <= 4'd0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            misr_q  <= misr_d;
            pi_q    <= pi_d;
            cnt_q   <= cnt_d;
            fcnt_q  <= fcnt_d;
            pass_q  <= pass_d;
        end
    end

    // Output decode
    always_comb begin
        pi_out        = pi_q;
        busy          = (state_q == S_RUN) || (state_q == S_FLUSH);
        done          = (state_q == S_DONE);
        pass          = pass_q;
        signature     = misr_q;
        pattern_count = cnt_q;
    end

endmodule
